// File: rtl/kp_pkg.sv
// Shared types and helpers for the keypad scanner.
package kp_pkg;

  // Scan sequencer states: dwell on a column, sample it, emit its events, step on.
  typedef enum logic [1:0] {
    StScan   = 2'd0,
    StSample = 2'd1,
    StEmit   = 2'd2,
    StNext   = 2'd3
  } kp_state_e;

  // Bits needed to index n items; never less than one so degenerate sizes still elaborate.
  function automatic int unsigned kp_clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Event words are packed as {press, code}: press in the MSB, key code below it.

endpackage

// File: rtl/kp_event_fifo.sv
// Synchronous event queue; pointers carry one extra wrap bit to tell full from empty.
module kp_event_fifo
  import kp_pkg::*;
#(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = kp_clog2(Depth);

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  // A push into a full queue is still taken when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: walks an active-low column, debounces every key over whole scans
// and queues press/release events for the consumer.
module keypad_scan_ctrl
  import kp_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CodeW     = kp_clog2(ROWS * COLS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ROWS-1:0]  row_i,
  output logic [COLS-1:0]  col_o,
  output logic             key_valid_o,
  input  logic             key_ready_i,
  output logic [CodeW-1:0] key_code_o,
  output logic             key_press_o,
  output logic             key_down_o,
  output logic             overflow_o,
  input  logic             clr_ovf_i
);

  localparam int unsigned NumKeys = ROWS * COLS;
  localparam int unsigned CntW    = kp_clog2(CLK_DIV);
  localparam int unsigned DbW     = kp_clog2(DEBOUNCE + 1);
  localparam int unsigned ColW    = kp_clog2(COLS);
  localparam int unsigned RowW    = kp_clog2(ROWS);
  localparam logic [COLS-1:0] ColReset = ~(COLS'(1));

  kp_state_e          state_q, state_d;
  logic [ROWS-1:0]    row_meta_q, row_sync_q;
  logic [CntW-1:0]    tick_q, tick_d;
  logic [COLS-1:0]    col_q, col_d;
  logic [ColW-1:0]    col_idx_q, col_idx_d;
  logic [NumKeys-1:0] deb_q, deb_d;
  logic [ROWS-1:0]    pend_q, pend_d;
  logic [DbW-1:0]     db_cnt_q [NumKeys];
  logic [DbW-1:0]     db_cnt_d [NumKeys];
  logic               ovf_q, ovf_d;

  logic               ev_push;
  logic [CodeW-1:0]   ev_code;
  logic               ev_press;
  logic [CodeW:0]     fifo_head;
  logic               fifo_full, fifo_empty, fifo_pop, drop;

  // Two-flop synchroniser; rows idle high through the pull-ups.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
    end
  end

  // Sequencer: dwell, sample + debounce the column, serialise pending keys, advance.
  always_comb begin
    int unsigned k;
    int unsigned sel;
    int unsigned col_base;
    logic        raw;
    state_d   = state_q;
    tick_d    = tick_q;
    col_d     = col_q;
    col_idx_d = col_idx_q;
    deb_d     = deb_q;
    pend_d    = pend_q;
    db_cnt_d  = db_cnt_q;
    ev_push   = 1'b0;
    ev_code   = '0;
    ev_press  = 1'b0;
    k         = 0;
    sel       = 0;
    raw       = 1'b0;
    col_base  = 32'(col_idx_q);
    unique case (state_q)
      StScan: begin
        if (tick_q == CntW'(CLK_DIV - 1)) state_d = StSample;
        else tick_d = tick_q + 1'b1;
      end
      StSample: begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          k   = r * COLS + col_base;
          raw = ~row_sync_q[r];
          if (raw == deb_q[CodeW'(k)]) begin
            db_cnt_d[CodeW'(k)] = '0;
          end else if (db_cnt_q[CodeW'(k)] == DbW'(DEBOUNCE - 1)) begin
            deb_d[CodeW'(k)]    = raw;
            db_cnt_d[CodeW'(k)] = '0;
            pend_d[r]           = 1'b1;
          end else begin
            db_cnt_d[CodeW'(k)] = db_cnt_q[CodeW'(k)] + 1'b1;
          end
        end
        state_d = StEmit;
      end
      StEmit: begin
        if (pend_q == '0) begin
          state_d = StNext;
        end else begin
          // Lowest pending row goes first.
          for (int r = ROWS - 1; r >= 0; r--) if (pend_q[r]) sel = 32'(r);
          k              = sel * COLS + col_base;
          ev_push        = 1'b1;
          ev_code        = CodeW'(k);
          ev_press       = deb_q[CodeW'(k)];
          pend_d[RowW'(sel)] = 1'b0;
        end
      end
      StNext: begin
        col_d     = (col_q << 1) | (col_q >> (COLS - 1));
        col_idx_d = (col_idx_q == ColW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
        tick_d    = '0;
        state_d   = StScan;
      end
      default: state_d = StScan;
    endcase
  end

  // Scanner state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StScan;
      tick_q    <= '0;
      col_q     <= ColReset;
      col_idx_q <= '0;
      deb_q     <= '0;
      pend_q    <= '0;
      for (int unsigned i = 0; i < NumKeys; i++) db_cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      col_q     <= col_d;
      col_idx_q <= col_idx_d;
      deb_q     <= deb_d;
      pend_q    <= pend_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign fifo_pop = ~fifo_empty & key_ready_i;
  assign drop     = ev_push & fifo_full & ~fifo_pop;

  kp_event_fifo #(
    .Width (CodeW + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ev_push),
    .data_i  ({ev_press, ev_code}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end

  assign col_o       = col_q;
  assign key_valid_o = ~fifo_empty;
  assign key_code_o  = fifo_head[CodeW-1:0];
  assign key_press_o = fifo_head[CodeW];
  assign key_down_o  = |deb_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives the rows, and a scan-period
// reference model predicts every output on every cycle.
module tb_keypad_scan_ctrl;

  localparam int ROWS = 4, COLS = 4, CLK_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int NK = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_ready, key_press, key_down, overflow, clr_ovf;
  logic [NK-1:0] keys;

  int n_checks = 0;
  int n_errors = 0;
  bit seen_valid;

  // Reference model state.
  int         m_off, m_col, m_k;
  bit         m_deb [NK];
  int         m_cnt [NK];
  logic [4:0] m_pend [$];
  logic [4:0] m_q [$];
  bit         m_ovf;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key ties its row to its column line.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .row_i(row), .col_o(col), .key_valid_o(key_valid),
    .key_ready_i(key_ready), .key_code_o(key_code), .key_press_o(key_press),
    .key_down_o(key_down), .overflow_o(overflow), .clr_ovf_i(clr_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_off = 0; m_col = 0; m_k = 0; m_ovf = 0;
    m_pend.delete(); m_q.delete();
    for (int i = 0; i < NK; i++) begin m_deb[i] = 0; m_cnt[i] = 0; end
  endtask

  // One column period = CLK_DIV dwell cycles, one sample, (events+1) emit cycles, one step.
  task automatic model_edge();
    bit pop, push, drop;
    logic [4:0] ev;
    int k;
    pop = key_ready && (m_q.size() > 0);
    push = 0; ev = '0;
    if (m_off == CLK_DIV) begin
      m_pend.delete();
      for (int r = 0; r < ROWS; r++) begin
        k = r * COLS + m_col;
        if (keys[k] == m_deb[k]) m_cnt[k] = 0;
        else begin
          m_cnt[k]++;
          if (m_cnt[k] == DEBOUNCE) begin
            m_deb[k] = keys[k];
            m_cnt[k] = 0;
            m_pend.push_back({m_deb[k], 4'(k)});
          end
        end
      end
      m_k = m_pend.size();
    end else if (m_off > CLK_DIV && m_off <= CLK_DIV + m_k) begin
      push = 1;
      ev = m_pend[m_off - CLK_DIV - 1];
    end
    if (pop) void'(m_q.pop_front());
    drop = 0;
    if (push) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(ev);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    if (m_off == CLK_DIV + m_k + 2) begin
      m_col = (m_col + 1) % COLS;
      m_off = 0;
    end else m_off++;
  endtask

  task automatic compare();
    logic [3:0] exp_col;
    bit any;
    exp_col = ~(4'b0001 << m_col);
    any = 0;
    for (int i = 0; i < NK; i++) any |= m_deb[i];
    check("col", col, exp_col);
    check("key_valid", key_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("key_code", key_code, m_q[0][3:0]);
      check("key_press", key_press, m_q[0][4]);
    end
    check("key_down", key_down, any);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare();
    if (key_valid) seen_valid = 1;
  endtask

  task automatic timeout(input string name);
    n_checks++; n_errors++;
    $display("FAIL %s: bound expired, got no event, required one", name);
  endtask

  task automatic wait_col_start(input int c);
    int i;
    i = 0;
    while (!(m_off == 0 && m_col == c) && i < 100) begin step(); i++; end
    if (i >= 100) timeout("col_start");
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i;
    i = 0;
    while (!key_valid && i < budget) begin step(); i++; end
    if (!key_valid) timeout(name);
  endtask

  task automatic pop_one();
    key_ready = 1; step(); key_ready = 0;
  endtask

  task automatic settle();
    keys = '0; key_ready = 1; clr_ovf = 1; step(); clr_ovf = 0;
    repeat (200) step();
    key_ready = 0;
  endtask

  initial begin
    int exp_codes[4];
    logic [3:0] drained [$];
    int i;
    keys = '0; key_ready = 0; clr_ovf = 0; seen_valid = 0;
    model_reset();
    repeat (3) step();
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 4'd0);
    check("rst_press", key_press, 1'b0);
    check("rst_down", key_down, 1'b0);
    rst = 0;

    // Press/release of key 6 (row 1, column 2).
    wait_col_start(2);
    keys[6] = 1;
    wait_valid(108, "press6");
    check("press6_code", key_code, 4'd6);
    check("press6_press", key_press, 1'b1);
    check("press6_down", key_down, 1'b1);
    pop_one();
    wait_col_start(2);
    keys[6] = 0;
    wait_valid(108, "release6");
    check("release6_code", key_code, 4'd6);
    check("release6_press", key_press, 1'b0);
    check("release6_down", key_down, 1'b0);
    pop_one();

    // Chatter on key 0: alternating samples never reach the threshold.
    settle();
    seen_valid = 0;
    for (int s = 0; s < 10; s++) begin
      wait_col_start(0);
      keys[0] = ~s[0];
      step();
    end
    repeat (50) step();
    check("chatter_valid", seen_valid, 1'b0);
    check("chatter_down", key_down, 1'b0);

    // Two keys in column 1 come out in row order.
    settle();
    wait_col_start(1);
    keys[1] = 1; keys[13] = 1;
    wait_valid(150, "multi");
    check("multi_code0", key_code, 4'd1);
    check("multi_press0", key_press, 1'b1);
    pop_one();
    check("multi_valid1", key_valid, 1'b1);
    check("multi_code1", key_code, 4'd13);
    check("multi_press1", key_press, 1'b1);
    pop_one();

    // Five presses against a stalled consumer: four kept, one dropped.
    settle();
    wait_col_start(0);
    keys[0] = 1; keys[4] = 1; keys[1] = 1; keys[2] = 1; keys[3] = 1;
    repeat (200) step();
    check("ovf_set", overflow, 1'b1);
    exp_codes = '{0, 4, 1, 2};
    for (int j = 0; j < 4; j++) begin
      check("drain_valid", key_valid, 1'b1);
      check("drain_code", key_code, 4'(exp_codes[j]));
      pop_one();
    end
    check("drain_empty", key_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    clr_ovf = 1; step(); clr_ovf = 0;
    check("ovf_clr", overflow, 1'b0);

    // Releases fill the queue; the fifth arrives together with a pop.
    wait_col_start(0);
    keys = '0;
    i = 0;
    while (!(m_q.size() == FIFO_DEPTH && m_off > CLK_DIV && m_off <= CLK_DIV + m_k) && i < 300) begin
      step(); i++;
    end
    if (i >= 300) timeout("full_push");
    key_ready = 1; step(); key_ready = 0;
    check("fullpp_ovf", overflow, 1'b0);
    check("fullpp_head", key_code, 4'd4);
    key_ready = 1;
    for (int j = 0; j < 20; j++) begin
      if (key_valid) drained.push_back(key_code);
      step();
    end
    key_ready = 0;
    check("fullpp_count", drained.size(), 4);
    if (drained.size() == 4) begin
      check("fullpp_c0", drained[0], 4'd4);
      check("fullpp_c3", drained[3], 4'd3);
    end

    // Random keys, backpressure and clears.
    for (int n = 0; n < 2500; n++) begin
      int idx;
      key_ready = 1'($urandom_range(0, 1));
      clr_ovf = ($urandom_range(0, 15) == 0);
      if (m_off == 0 && $urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, NK - 1);
        keys[idx] = ~keys[idx];
      end
      step();
    end
    clr_ovf = 0; key_ready = 0;

    // Asynchronous reset between clock edges, then the column walk.
    repeat (5) step();
    #2 rst = 1;
    #1;
    check("arst_col", col, 4'b1110);
    check("arst_valid", key_valid, 1'b0);
    check("arst_ovf", overflow, 1'b0);
    check("arst_down", key_down, 1'b0);
    model_reset();
    keys = '0;
    repeat (2) step();
    rst = 0;
    repeat (10) step();
    check("walk_hold", col, 4'b1110);
    step();
    check("walk_1", col, 4'b1101);
    repeat (11) step();
    check("walk_2", col, 4'b1011);
    repeat (11) step();
    check("walk_3", col, 4'b0111);
    repeat (11) step();
    check("walk_wrap", col, 4'b1110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
